// File: rtl/btn_event_decoder.sv
// Four-channel push-button event decoder.
// Each channel turns a debounced, active-high button level into press,
// short-release, long-press and auto-repeat pulses plus a held level.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat while held in LONG).
// Without the macro o_repeat is tied low and the hold counter stays at 0 in LONG.
module btn_event_decoder #(
  parameter int LONG_PRESS_CYC = 100_000_000,
  parameter int REPEAT_CYC     = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_btn,
  output logic [3:0] o_press,
  output logic [3:0] o_short,
  output logic [3:0] o_long,
  output logic [3:0] o_repeat,
  output logic [3:0] o_held
);

  localparam int MAX_CYC = (LONG_PRESS_CYC > REPEAT_CYC) ? LONG_PRESS_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

  // LOCKOUT waits for a release so a button held through reset never fires.
  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             press_reg, press_next;
      logic             short_reg, short_next;
      logic             long_reg, long_next;
      logic             held_reg, held_next;
`ifdef BTN_AUTO_REPEAT_EN
      logic             repeat_reg, repeat_next;
`endif

      // State, hold counter and registered event outputs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg  <= ST_LOCKOUT;
          cnt_reg    <= '0;
          press_reg  <= 1'b0;
          short_reg  <= 1'b0;
          long_reg   <= 1'b0;
          held_reg   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
          repeat_reg <= 1'b0;
`endif
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          press_reg  <= press_next;
          short_reg  <= short_next;
          long_reg   <= long_next;
          held_reg   <= held_next;
`ifdef BTN_AUTO_REPEAT_EN
          repeat_reg <= repeat_next;
`endif
        end
      end

      // Next-state, counter and event decode; the counter is cleared on every state entry.
      always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_next  = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_next = 1'b0;
`endif
        case (state_reg)
          ST_LOCKOUT: begin
            if (!i_btn[gi]) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          end
          ST_IDLE: begin
            if (i_btn[gi]) begin
              state_next = ST_PRESSED;
              cnt_next   = '0;
              press_next = 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!i_btn[gi]) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              short_next = 1'b1;
            end else if (cnt_reg == LONG_LAST) begin
              state_next = ST_LONG;
              cnt_next   = '0;
              long_next  = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          ST_LONG: begin
            if (!i_btn[gi]) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
`ifdef BTN_AUTO_REPEAT_EN
              if (cnt_reg == REPEAT_LAST) begin
                cnt_next    = '0;
                repeat_next = 1'b1;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
`else
              cnt_next = '0;
`endif
            end
          end
          default: begin
            state_next = ST_LOCKOUT;
            cnt_next   = '0;
          end
        endcase
        held_next = (state_next == ST_PRESSED) || (state_next == ST_LONG);
      end

      assign o_press[gi] = press_reg;
      assign o_short[gi] = short_reg;
      assign o_long[gi]  = long_reg;
      assign o_held[gi]  = held_reg;
`ifdef BTN_AUTO_REPEAT_EN
      assign o_repeat[gi] = repeat_reg;
`endif
    end
  endgenerate

`ifndef BTN_AUTO_REPEAT_EN
  assign o_repeat = 4'b0000;
`endif

endmodule

// File: doc/btn_event_decoder.md
BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
REQ-001 Parameter LONG_PRESS_CYC, default 100_000_000, is the number of clk cycles held before a long-press event (legal >= 2).
REQ-002 Parameter REPEAT_CYC, default 20_000_000, is the auto-repeat period in clk cycles after a long press (legal >= 1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_btn  input  4  debounced button levels, active-high, synchronous to clk; bit3 UP, bit2 DOWN, bit1 LEFT, bit0 RIGHT.
REQ-006 o_press  output  4  one-cycle pulse per bit on press detection.
REQ-007 o_short  output  4  one-cycle pulse per bit on release before long threshold.
REQ-008 o_long  output  4  one-cycle pulse per bit when hold reaches LONG_PRESS_CYC.
REQ-009 o_repeat  output  4  one-cycle pulse per bit every REPEAT_CYC while held after long.
REQ-010 o_held  output  4  level, high while the channel is in PRESSED or LONG.

Function
REQ-011 The block SHALL contain four independent identical channels; no channel's events SHALL affect another, and simultaneous events on several bits SHALL all be reported in the same cycle.
REQ-012 Each channel SHALL implement states LOCKOUT, IDLE, PRESSED, LONG with one hold counter of width $clog2(max(LONG_PRESS_CYC, REPEAT_CYC)+1).
REQ-013 LOCKOUT -> IDLE on the first edge sampling i_btn=0; no event is generated in LOCKOUT.
REQ-014 IDLE -> PRESSED on the edge sampling i_btn=1; counter cleared to 0; o_press high for the following cycle only (latency 1 cycle).
REQ-015 In PRESSED with i_btn=1 the counter SHALL increment each cycle; on the edge where counter equals LONG_PRESS_CYC-1 the channel SHALL go to LONG, clear the counter and pulse o_long the following cycle, so o_long follows o_press by exactly LONG_PRESS_CYC cycles.
REQ-016 PRESSED with i_btn=0 -> IDLE with o_short pulsed the following cycle; a one-cycle press SHALL yield o_press then o_short on consecutive cycles.
REQ-017 LONG with i_btn=0 -> IDLE with no o_short and no o_repeat.
REQ-018 The counter SHALL never wrap; it is cleared on every state entry and compared with == only.
REQ-019 o_held SHALL be registered and high exactly in the cycles following entry into PRESSED up to and including the cycle state leaves LONG/PRESSED.
REQ-020 All outputs SHALL be registered; no combinational path from i_btn to any output.

Reset
REQ-021 On rst assertion, regardless of clk, every channel SHALL enter LOCKOUT, counters SHALL clear, and o_press, o_short, o_long, o_repeat, o_held SHALL all be 4'b0000.
REQ-022 Reset mid-press SHALL abort the event sequence; a button still held after rst deasserts SHALL produce no event until it is released and pressed again.

Configuration
REQ-023 Macro BTN_AUTO_REPEAT_EN: when defined, in LONG with i_btn=1 the counter SHALL increment and, on the edge where it equals REPEAT_CYC-1, clear and pulse o_repeat the following cycle.
REQ-024 When BTN_AUTO_REPEAT_EN is undefined, o_repeat SHALL be constant 4'b0000 and the counter SHALL hold at 0 in LONG; all other behaviour unchanged.

Verification (LONG_PRESS_CYC=10, REPEAT_CYC=4)
REQ-025 Reset then i_btn=4'b0000, pulse bit0 high for 3 cycles -> o_press[0] at cycle 1, o_held[0] 3 cycles, o_short[0] one cycle later; no o_long.
REQ-026 Hold bit3 for 20 cycles with macro defined -> o_press[3]; o_long[3] 10 cycles later; o_repeat[3] every 4 cycles thereafter (2 pulses); release gives no o_short.
REQ-027 Same stimulus with macro undefined -> o_long[3] once, o_repeat stays 4'b0000.
REQ-028 Hold i_btn=4'b1111 during and after rst deassert -> no events; release all, press bit2 -> only o_press[2].
REQ-029 Press bit1 and bit0 on the same edge, release bit0 after 2 cycles, bit1 after 12 -> o_press=4'b0011 same cycle, o_short[0], o_long[1], no cross-talk.
REQ-030 Assert rst for one cycle while bit2 is in LONG -> all outputs 0 next cycle; no o_repeat until release and re-press.
